// File: rtl/store_buf_pkg.sv
// Shared types and helpers for the store buffer between EX/MEM and the 64x32 data memory.
package store_buf_pkg;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } sb_entry_t;

    // Pointer width for a power-of-two buffer depth.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/store_buf_fwd_match.sv
// Address compare across all buffer entries with youngest-first priority select.
// Serves both load forwarding and the store-coalesce lookup.
module store_buf_fwd_match
    import store_buf_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = ptr_w(DEPTH)
) (
    input  sb_entry_t                entries [DEPTH],
    input  logic [PW-1:0]            tail,
    input  logic [ADDR_W-1:0]        ld_addr,
    output logic                     hit,
    output logic [PW-1:0]            idx,
    output logic [DATA_W-1:0]        data
);

    logic [PW-1:0] pos;

    // Walk oldest to youngest so the last match found is the youngest.
    always_comb begin
        hit  = 1'b0;
        idx  = '0;
        data = '0;
        pos  = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            pos = tail - PW'(k);
            if (entries[pos].valid && (entries[pos].addr == ld_addr)) begin
                hit  = 1'b1;
                idx  = pos;
                data = entries[pos].data;
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Circular store buffer with load forwarding; drains one store per cycle when no load owns the port.
// Optional in-place store coalescing is enabled by defining STORE_BUF_COALESCE_EN.
module store_buffer
    import store_buf_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = store_buf_pkg::ADDR_W,
    parameter int DATA_W = store_buf_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              st_valid,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [DATA_W-1:0] st_data,
    output logic              st_ready,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_addr,
    output logic [DATA_W-1:0] ld_data,
    output logic              ld_fwd,
    output logic              stall,
    output logic              empty,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int PW = ptr_w(DEPTH);

    logic [PW-1:0]     head, tail;
    logic [PW:0]       count;
    logic [DEPTH-1:0]  vld;
    logic [ADDR_W-1:0] ent_addr [DEPTH];
    logic [DATA_W-1:0] ent_data [DEPTH];
    sb_entry_t         ents     [DEPTH];

    logic              full, drain, accept, alloc, merge, coalesce;
    logic              fwd_hit;
    logic [PW-1:0]     fwd_idx, st_idx;
    logic [DATA_W-1:0] fwd_data;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ents[i] = '{valid: vld[i], addr: ent_addr[i], data: ent_data[i]};
        end
    end

    assign full  = (count == (PW+1)'(DEPTH));
    assign empty = (count == '0);
    // Loads own the memory port; reset suppresses any in-flight write.
    assign drain = !ld_valid && !empty && !rst;

    store_buf_fwd_match #(.DEPTH(DEPTH)) u_fwd (
        .entries (ents),
        .tail    (tail),
        .ld_addr (ld_addr),
        .hit     (fwd_hit),
        .idx     (fwd_idx),
        .data    (fwd_data)
    );

`ifdef STORE_BUF_COALESCE_EN
    logic              st_hit;
    logic [DATA_W-1:0] st_match_data;

    store_buf_fwd_match #(.DEPTH(DEPTH)) u_coalesce (
        .entries (ents),
        .tail    (tail),
        .ld_addr (st_addr),
        .hit     (st_hit),
        .idx     (st_idx),
        .data    (st_match_data)
    );

    // A hit on the head that leaves this cycle must allocate a fresh entry.
    assign coalesce = st_hit && !(drain && (st_idx == head));
    assign st_ready = !full || st_hit;
    wire unused_match = &{1'b0, fwd_idx, st_match_data};
`else
    assign st_idx   = '0;
    assign coalesce = 1'b0;
    assign st_ready = !full;
    wire unused_match = &{1'b0, fwd_idx};
`endif

    assign accept = st_valid && st_ready && !rst;
    assign alloc  = accept && !coalesce;
    assign merge  = accept && coalesce;
    assign stall  = st_valid && !st_ready && !rst;

    assign mem_we    = drain;
    assign mem_addr  = drain ? ent_addr[head] : ld_addr;
    assign mem_wdata = ent_data[head];
    assign ld_fwd    = fwd_hit;
    assign ld_data   = fwd_hit ? fwd_data : mem_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            vld   <= '0;
        end else begin
            if (drain) begin
                vld[head] <= 1'b0;
                head      <= head + 1'b1;
            end
            // Allocation after the drain clear so a full buffer reusing the head slot stays valid.
            if (alloc) begin
                vld[tail] <= 1'b1;
                tail      <= tail + 1'b1;
            end
            count <= count + (PW+1)'(alloc) - (PW+1)'(drain);
        end
    end

    always_ff @(posedge clk) begin
        if (alloc) begin
            ent_addr[tail] <= st_addr;
            ent_data[tail] <= st_data;
        end else if (merge) begin
            ent_data[st_idx] <= st_data;
        end
    end

endmodule
